mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 97 +++++++++
 tb/tb_mem_wb_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access FSM with MEM/WB pipeline register and load/store formatting
module mem_wb_stage #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  Funct3M,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        StallM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        RegWriteW,
  output logic [4:0]  RDW,
  output logic [31:0] ResultW,
  output logic        MisalignW,
  output logic        BusErrW
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1) < 1 ? 1 : $clog2(ACK_TIMEOUT + 1);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic we_q, rw_q;
  logic [1:0] src_q, src_w;
  logic [2:0] f3_q;
  logic [4:0] rd_q;
  logic [3:0] be_q, be_m;
  logic [31:0] pc4_q, wd_q, alu_q, wd_m, alu_w, pc4_w, ld_w, ld_fmt, lane;
  logic is_b, is_h, mis, mem_op, idle, issue, tout, done;
  // decode the M-stage access and the request/stall handshake
  always_comb begin
    is_b = Funct3M == 3'b000 || Funct3M == 3'b100;
    is_h = Funct3M == 3'b001 || Funct3M == 3'b101;
    mis = is_h ? ALU_ResultM[0] : is_b ? 1'b0 : |ALU_ResultM[1:0];
    be_m = is_b ? 4'b0001 << ALU_ResultM[1:0] : is_h ? (ALU_ResultM[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd_m = is_b ? {4{WriteDataM[7:0]}} : is_h ? {2{WriteDataM[15:0]}} : WriteDataM;
    mem_op = MemWriteM || ResultSrcM == 2'b01;
    idle = state == IDLE;
    issue = idle && mem_op && !mis;
    tout = !idle && cnt == CW'(ACK_TIMEOUT);
    done = !idle && !tout && dmem_ack;
    dmem_req = !rst && (issue || (!idle && !tout));
    StallM = !rst && (issue || (!idle && !tout && !dmem_ack));
    dmem_we = dmem_req && (idle ? MemWriteM : we_q);
    dmem_addr = idle ? {ALU_ResultM[31:2], 2'b00} : {alu_q[31:2], 2'b00};
    dmem_be = idle ? be_m : be_q;
    dmem_wdata = idle ? wd_m : wd_q;
    state_nx = idle ? (issue ? WAIT : IDLE) : (tout || dmem_ack ? IDLE : WAIT);
  end
  // select the addressed lane of the read word and extend it per load type
  always_comb begin
    lane = dmem_rdata >> {alu_q[1:0], 3'b000};
    ld_fmt = f3_q == 3'b000 ? {{24{lane[7]}}, lane[7:0]} :
             f3_q == 3'b001 ? {{16{lane[15]}}, lane[15:0]} :
             f3_q == 3'b100 ? {24'b0, lane[7:0]} :
             f3_q == 3'b101 ? {16'b0, lane[15:0]} : dmem_rdata;
  end
  // write-back result mux; reserved select 11 behaves as ALU result
  always_comb ResultW = src_w == 2'b01 ? ld_w : src_w == 2'b10 ? pc4_w : alu_w;
  // FSM state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // capture the accepted access so the bus stays stable while waiting
  always_ff @(posedge clk)
    if (issue) begin
      {we_q, rw_q, src_q, f3_q, rd_q} <= {MemWriteM, RegWriteM, ResultSrcM, Funct3M, RD_M};
      {be_q, wd_q, alu_q, pc4_q} <= {be_m, wd_m, ALU_ResultM, PCPlus4M};
    end
  // timeout counter and W register; anything not explicitly loaded is a zero bubble
  always_ff @(posedge clk) begin
    {RegWriteW, RDW, src_w, alu_w, pc4_w, ld_w, MisalignW, BusErrW} <= '0;
    if (rst)
      cnt <= '0;
    else if (idle) begin
      cnt <= '0;
      if (!mem_op)
        {RegWriteW, RDW, src_w, alu_w, pc4_w} <= {RegWriteM, RD_M, ResultSrcM, ALU_ResultM, PCPlus4M};
      else if (mis)
        MisalignW <= 1'b1;
    end else if (tout)
      BusErrW <= 1'b1;
    else if (done) begin
      {RegWriteW, RDW, src_w, alu_w, pc4_w} <= {rw_q, rd_q, src_q, alu_q, pc4_q};
      ld_w <= we_q ? 32'b0 : ld_fmt;
    end else
      cnt <= cnt + 1'b1;
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed and random memory ops against a behavioural access model
module tb_mem_wb_stage;
  localparam int TO = 4;
  logic clk = 0, rst = 1;
  logic RegWriteM, MemWriteM, dmem_ack;
  logic [1:0] ResultSrcM;
  logic [2:0] Funct3M;
  logic [4:0] RD_M, RDW;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM, dmem_rdata, dmem_addr, dmem_wdata, ResultW;
  logic StallM, dmem_req, dmem_we, RegWriteW, MisalignW, BusErrW;
  logic [3:0] dmem_be;
  int checks = 0, errors = 0;
  mem_wb_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .RegWriteW(RegWriteW),
    .RDW(RDW), .ResultW(ResultW), .MisalignW(MisalignW), .BusErrW(BusErrW)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic int size_of(input logic [2:0] f3);
    return (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
  endfunction
  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] a);
    int m;
    m = ((1 << size_of(f3)) - 1) << a;
    return m[3:0];
  endfunction
  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] wd);
    return size_of(f3) == 1 ? wd[7:0] * 32'h01010101 : size_of(f3) == 2 ? wd[15:0] * 32'h00010001 : wd;
  endfunction
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d);
    int sz;
    longint m;
    logic [31:0] v;
    sz = size_of(f3);
    if (sz == 4) return d;
    m = (64'd1 << (8 * sz)) - 1;
    v = (d >> (8 * a)) & m[31:0];
    if (!f3[2] && v[8 * sz - 1]) v = v | ~m[31:0];
    return v;
  endfunction
  task automatic nop();
    {RegWriteM, MemWriteM, ResultSrcM, Funct3M, RD_M} = '0;
    {PCPlus4M, WriteDataM, ALU_ResultM} = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic rw, mw, input logic [1:0] src, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] pc4, wd, alu, rdat, input int ack_at);
    int sz;
    bit mem, mis, ack, to;
    logic [31:0] res;
    sz = size_of(f3);
    mem = mw || src == 2'b01;
    mis = (int'(alu[1:0]) % sz) != 0;
    {RegWriteM, MemWriteM, ResultSrcM, Funct3M, RD_M} = {rw, mw, src, f3, rd};
    {PCPlus4M, WriteDataM, ALU_ResultM, dmem_rdata, dmem_ack} = {pc4, wd, alu, rdat, 1'b0};
    #3;
    if (!mem) begin
      chk("nm_stall", StallM, 0);
      chk("nm_req", dmem_req, 0);
      tick();
      chk("nm_rw", RegWriteW, rw);
      chk("nm_rd", RDW, rd);
      chk("nm_res", ResultW, src == 2'b10 ? pc4 : alu);
      chk("nm_mis", MisalignW, 0);
      return;
    end
    if (mis) begin
      chk("mis_req", dmem_req, 0);
      chk("mis_stall", StallM, 0);
      tick();
      chk("mis_rw", RegWriteW, 0);
      chk("mis_flag", MisalignW, 1);
      chk("mis_berr", BusErrW, 0);
      nop();
      tick();
      chk("mis_once", MisalignW, 0);
      return;
    end
    chk("iss_req", dmem_req, 1);
    chk("iss_stall", StallM, 1);
    chk("iss_we", dmem_we, mw);
    chk("iss_addr", dmem_addr, {alu[31:2], 2'b00});
    chk("iss_be", dmem_be, exp_be(f3, alu[1:0]));
    if (mw) chk("iss_wd", dmem_wdata, exp_wd(f3, wd));
    tick();
    chk("iss_bub_rw", RegWriteW, 0);
    chk("iss_bub_rd", RDW, 0);
    for (int k = 1; k <= TO + 1; k++) begin
      ack = k == ack_at;
      to = k == TO + 1;
      dmem_ack = ack;
      #3;
      if (to) begin
        chk("to_req", dmem_req, 0);
        chk("to_stall", StallM, 0);
      end else begin
        chk("w_req", dmem_req, 1);
        chk("w_stall", StallM, !ack);
        chk("w_addr", dmem_addr, {alu[31:2], 2'b00});
        chk("w_be", dmem_be, exp_be(f3, alu[1:0]));
        chk("w_we", dmem_we, mw);
        if (mw) chk("w_wd", dmem_wdata, exp_wd(f3, wd));
      end
      tick();
      dmem_ack = 0;
      if (ack) begin
        res = src == 2'b01 ? exp_load(f3, alu[1:0], rdat) : src == 2'b10 ? pc4 : alu;
        chk("ack_rw", RegWriteW, rw);
        chk("ack_rd", RDW, rd);
        chk("ack_res", ResultW, res);
        chk("ack_flags", {MisalignW, BusErrW}, 0);
        return;
      end
      if (to) begin
        chk("to_rw", RegWriteW, 0);
        chk("to_berr", BusErrW, 1);
        chk("to_rd", RDW, 0);
        nop();
        dmem_ack = 1;
        #3;
        chk("late_req", dmem_req, 0);
        chk("late_stall", StallM, 0);
        tick();
        dmem_ack = 0;
        chk("berr_once", BusErrW, 0);
        chk("late_rw", RegWriteW, 0);
        return;
      end
      chk("bub_rw", RegWriteW, 0);
      chk("bub_rd", RDW, 0);
    end
  endtask
  initial begin
    logic mw;
    logic [1:0] src;
    nop();
    dmem_ack = 0;
    dmem_rdata = 0;
    tick();
    tick();
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", StallM, 0);
    chk("rst_w", {RegWriteW, RDW, ResultW, MisalignW, BusErrW}, 0);
    rst = 0;
    run_op(1, 0, 2'b00, 3'b000, 5, 32'h8, 0, 32'h1234, 0, 0);
    run_op(1, 0, 2'b01, 3'b000, 7, 32'h44, 0, 32'h103, 32'h80FFFFFF, 3);
    run_op(0, 1, 2'b00, 3'b001, 0, 32'h48, 32'hAAAABEEF, 32'h202, 0, 1);
    run_op(1, 0, 2'b01, 3'b010, 3, 32'h4C, 0, 32'h101, 0, 0);
    run_op(1, 0, 2'b01, 3'b010, 9, 32'h50, 0, 32'h400, 0, 0);
    run_op(1, 0, 2'b10, 3'b000, 1, 32'h54, 0, 32'h9, 0, 0);
    run_op(1, 0, 2'b11, 3'b000, 2, 32'h58, 0, 32'h77, 0, 0);
    for (int i = 0; i < 60; i++) begin
      mw = 1'($urandom_range(0, 1));
      src = mw ? 2'b00 : 2'($urandom_range(0, 3));
      run_op(1'($urandom_range(0, 1)), mw, src, 3'($urandom_range(0, 7)), 5'($urandom),
             $urandom, $urandom, $urandom, $urandom, $urandom_range(0, TO));
    end
    {RegWriteM, MemWriteM, ResultSrcM, Funct3M, RD_M} = {1'b1, 1'b0, 2'b01, 3'b010, 5'd4};
    ALU_ResultM = 32'h400;
    tick();
    tick();
    rst = 1;
    nop();
    tick();
    chk("wrst_req", dmem_req, 0);
    chk("wrst_stall", StallM, 0);
    chk("wrst_w", {RegWriteW, RDW, ResultW, MisalignW, BusErrW}, 0);
    rst = 0;
    dmem_ack = 1;
    dmem_rdata = 32'hDEADBEEF;
    #3;
    chk("wrst_late_req", dmem_req, 0);
    chk("wrst_late_stall", StallM, 0);
    tick();
    dmem_ack = 0;
    chk("wrst_late_rw", RegWriteW, 0);
    chk("wrst_late_res", ResultW, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
